// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory access stage: store-size and load-kind
// encodings, FSM state encoding and the alignment predicate.
package mem_access_stage_pkg;

  // Store size encodings carried in the EX/MEM control bundle
  localparam logic [1:0] SC_NONE = 2'd0;
  localparam logic [1:0] SC_WORD = 2'd1;
  localparam logic [1:0] SC_HALF = 2'd2;
  localparam logic [1:0] SC_BYTE = 2'd3;

  // Load kind encodings carried in the EX/MEM control bundle
  localparam logic [2:0] LC_NONE = 3'd0;
  localparam logic [2:0] LC_LW   = 3'd1;
  localparam logic [2:0] LC_LH   = 3'd2;
  localparam logic [2:0] LC_LHU  = 3'd3;
  localparam logic [2:0] LC_LB   = 3'd4;
  localparam logic [2:0] LC_LBU  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Word accesses need both low address bits clear, halfword accesses need bit 0 clear
  function automatic logic is_misaligned(input logic [1:0] sc,
                                         input logic [2:0] lc,
                                         input logic [1:0] addr_lo);
    logic word_acc;
    logic half_acc;
    word_acc = (sc == SC_WORD) || (lc == LC_LW);
    half_acc = (sc == SC_HALF) || (lc == LC_LH) || (lc == LC_LHU);
    return (word_acc && (addr_lo != 2'b00)) || (half_acc && addr_lo[0]);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: picks the addressed lane out of the read word and
// sign- or zero-extends it according to the load kind.
module mem_access_stage_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_lc,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];

  // Extend the selected lane to a full word according to the load kind
  always_comb begin
    o_data = '0;
    case (i_lc)
      LC_NONE: o_data = '0;
      LC_LW:   o_data = i_rdata;
      LC_LH:   o_data = {{16{w_half[15]}}, w_half};
      LC_LHU:  o_data = {16'h0000, w_half};
      LC_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LC_LBU:  o_data = {24'h000000, w_byte};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory pipeline stage: issues data-memory accesses over the req/ack bus,
// stalls upstream while an access is in flight, and holds the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cs,
  input  logic              i_dm_w,
  input  logic              i_dm_r,
  input  logic [1:0]        i_sc,
  input  logic [2:0]        i_lc,
  input  logic [ADDR_W-1:0] i_dmem_addr,
  input  logic [31:0]       i_data_in,
  input  logic [31:0]       i_aluo,
  input  logic [31:0]       i_instr,
  input  logic [3:0]        i_doing_op,
  mem_access_stage_if.master io_mem,
  output logic              o_stall,
  output logic [31:0]       o_wb_data,
  output logic [31:0]       o_instr_mem_wb,
  output logic [3:0]        o_doing_op_mem_wb,
  output logic              o_misalign,
  output logic              o_bus_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [1:0]        r_addr_lo;
  logic [2:0]        r_lc;
  logic              r_is_load;
  logic [31:0]       r_rdata;
  logic              r_timeout;
  logic [7:0]        r_count;

  logic [31:0]       r_wb_data;
  logic [31:0]       r_instr_wb;
  logic [3:0]        r_op_wb;
  logic              r_misalign;
  logic              r_bus_err;

  logic              w_misaligned;
  logic              w_issue;
  logic              w_stall;
  logic              w_timeout_hit;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  assign w_misaligned  = is_misaligned(i_sc, i_lc, i_dmem_addr[1:0]);
  assign w_issue       = i_cs && !w_misaligned;
  assign w_stall       = (r_state == ST_BUSY) || ((r_state == ST_IDLE) && w_issue);
  assign w_timeout_hit = (r_count == TIMEOUT_LAST);

  // Place store data on its byte lanes and build the matching byte enables
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_data_in;
    if (i_dm_w) begin
      case (i_sc)
        SC_BYTE: begin
          w_be    = 4'b0001 << i_dmem_addr[1:0];
          w_wdata = {4{i_data_in[7:0]}};
        end
        SC_HALF: begin
          w_be    = i_dmem_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{i_data_in[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = i_data_in;
        end
      endcase
    end
  end

  // Access FSM: issue from IDLE, wait for ack or timeout in BUSY, one RESP cycle to retire
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_addr_lo   <= 2'b00;
      r_lc        <= LC_NONE;
      r_is_load   <= 1'b0;
      r_rdata     <= '0;
      r_timeout   <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_dm_w;
            r_mem_be    <= w_be;
            r_mem_addr  <= {i_dmem_addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_addr_lo   <= i_dmem_addr[1:0];
            r_lc        <= i_lc;
            r_is_load   <= i_dm_r;
            r_timeout   <= 1'b0;
            r_count     <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_timeout_hit) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_RESP;
          end else if (io_mem.mem_ack) begin
            r_rdata   <= io_mem.mem_rdata;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= ST_RESP;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register: advances only when the pipeline is not stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data  <= '0;
      r_instr_wb <= '0;
      r_op_wb    <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else if (!w_stall) begin
      r_instr_wb <= i_instr;
      r_op_wb    <= i_doing_op;
      if (r_state == ST_RESP) begin
        r_misalign <= 1'b0;
        r_bus_err  <= r_timeout;
        if (r_timeout) r_wb_data <= '0;
        else           r_wb_data <= r_is_load ? w_load_data : i_aluo;
      end else if (i_cs && w_misaligned) begin
        r_wb_data  <= '0;
        r_misalign <= 1'b1;
        r_bus_err  <= 1'b0;
      end else begin
        r_wb_data  <= i_aluo;
        r_misalign <= 1'b0;
        r_bus_err  <= 1'b0;
      end
    end
  end

  mem_access_stage_load_align u_load_align (
    .i_rdata   (r_rdata),
    .i_addr_lo (r_addr_lo),
    .i_lc      (r_lc),
    .o_data    (w_load_data)
  );

  assign io_mem.mem_req   = r_mem_req;
  assign io_mem.mem_we    = r_mem_we;
  assign io_mem.mem_be    = r_mem_be;
  assign io_mem.mem_addr  = r_mem_addr;
  assign io_mem.mem_wdata = r_mem_wdata;

  assign o_stall           = w_stall;
  assign o_wb_data         = r_wb_data;
  assign o_instr_mem_wb    = r_instr_wb;
  assign o_doing_op_mem_wb = r_op_wb;
  assign o_misalign        = r_misalign;
  assign o_bus_err         = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: drives EX/MEM bundles, acts as the memory
// slave, and checks MEM/WB results through an expected-result queue.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int ACK_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, dmW, dmR;
  logic [1:0]  sc;
  logic [2:0]  lc;
  logic [31:0] dmemAddr, dataIn, aluo, instr;
  logic [3:0]  doingOp;
  logic        oStall, oMisalign, oBusErr;
  logic [31:0] oWbData, oInstrWb;
  logic [3:0]  oOpWb;

  mem_access_stage_if #(.ADDR_W(32)) bus ();

  mem_access_stage #(.ACK_TIMEOUT(ACK_TIMEOUT), .ADDR_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_cs              (cs),
    .i_dm_w            (dmW),
    .i_dm_r            (dmR),
    .i_sc              (sc),
    .i_lc              (lc),
    .i_dmem_addr       (dmemAddr),
    .i_data_in         (dataIn),
    .i_aluo            (aluo),
    .i_instr           (instr),
    .i_doing_op        (doingOp),
    .io_mem            (bus),
    .o_stall           (oStall),
    .o_wb_data         (oWbData),
    .o_instr_mem_wb    (oInstrWb),
    .o_doing_op_mem_wb (oOpWb),
    .o_misalign        (oMisalign),
    .o_bus_err         (oBusErr)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct packed {
    logic [31:0] wb;
    logic [31:0] ins;
    logic [3:0]  op;
    logic        mis;
    logic        err;
  } wb_t;

  typedef struct {
    string       name;
    logic        cs, dmW, dmR;
    logic [1:0]  sc;
    logic [2:0]  lc;
    logic [31:0] addr, dataIn, aluo, instr;
    logic [3:0]  op;
    logic [31:0] rdata;
    int          ackAfter;
    logic        ackInResp;
    int          expStall, expReq;
    logic [68:0] expBus;
    wb_t         expWb;
  } vec_t;

  wb_t wbActual;
  assign wbActual = {oWbData, oInstrWb, oOpWb, oMisalign, oBusErr};

  wb_t expQ[$];
  int  nVectors = 0;
  int  nMiscompares = 0;

  function automatic vec_t mk(input string name, input logic c, input logic w, input logic r,
                              input logic [1:0] s, input logic [2:0] l, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] alu, input logic [31:0] ins,
                              input logic [3:0] op, input logic [31:0] rd, input int ackAfter,
                              input logic ackInResp, input int expStall, input int expReq,
                              input logic [68:0] expBus, input logic [31:0] expData,
                              input logic expMis, input logic expErr);
    vec_t v;
    v.name = name; v.cs = c; v.dmW = w; v.dmR = r; v.sc = s; v.lc = l;
    v.addr = a; v.dataIn = d; v.aluo = alu; v.instr = ins; v.op = op; v.rdata = rd;
    v.ackAfter = ackAfter; v.ackInResp = ackInResp;
    v.expStall = expStall; v.expReq = expReq; v.expBus = expBus;
    v.expWb = {expData, ins, op, expMis, expErr};
    return v;
  endfunction

  // Drives one EX/MEM bundle, plays the memory slave, returns what it observed.
  // Entered just after a rising edge; returns just after the edge that retires the op.
  task automatic run_access(input vec_t v, output int stallCyc, output int reqCyc,
                            output logic [68:0] busSnap, output logic busMoved);
    logic [68:0] cur;
    logic        seenReq;
    cs = v.cs; dmW = v.dmW; dmR = v.dmR; sc = v.sc; lc = v.lc;
    dmemAddr = v.addr; dataIn = v.dataIn; aluo = v.aluo; instr = v.instr; doingOp = v.op;
    expQ.push_back(v.expWb);
    stallCyc = 0; reqCyc = 0; busSnap = '0; busMoved = 1'b0; seenReq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (oStall === 1'b1) stallCyc++;
      if (bus.mem_req === 1'b1) begin
        reqCyc++;
        cur = {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
        if (!seenReq) busSnap = cur;
        else if (cur !== busSnap) busMoved = 1'b1;
        seenReq = 1'b1;
      end
      bus.mem_ack = ((bus.mem_req === 1'b1) && (reqCyc == v.ackAfter)) ||
                    (v.ackInResp && seenReq && (oStall !== 1'b1));
      bus.mem_rdata = bus.mem_ack ? v.rdata : 32'h0;
      if (oStall !== 1'b1) break;
    end
    @(posedge clk); #1;
    cs = 1'b0; dmW = 1'b0; dmR = 1'b0; sc = SC_NONE; lc = LC_NONE;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    cs = 0; dmW = 0; dmR = 0; sc = SC_NONE; lc = LC_NONE; dmemAddr = 0; dataIn = 0;
    aluo = 32'hFFFF_FFFF; instr = 32'hFFFF_FFFF; doingOp = 4'hF;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nVectors++;
    if ({oStall, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 71'h0) begin
      nMiscompares++;
      $display("[TB] FAIL reset bus/stall: got stall=%b req=%b we=%b be=%b addr=%h wdata=%h expected all 0",
               oStall, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    nVectors++;
    if (wbActual !== 70'h0) begin
      nMiscompares++;
      $display("[TB] FAIL reset MEM/WB: got %h expected 0", wbActual);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    aluo = 0; instr = 0; doingOp = 0;
  endtask

  task automatic test_alu_pass();
    vec_t tbl[2];
    int stallCyc, reqCyc; logic [68:0] snap; logic moved; wb_t exp;
    tbl[0] = mk("alu", 0,0,0, SC_NONE, LC_NONE, 32'h0, 32'h0, 32'h1234_5678, 32'h0000_0013, 4'd3,
                32'h0, 0, 0, 0, 0, 69'h0, 32'h1234_5678, 0, 0);
    tbl[1] = mk("alu_nocs", 0,0,1, SC_NONE, LC_LW, 32'h2002, 32'h0, 32'h0BAD_F00D, 32'h0000_0093, 4'd4,
                32'h0, 0, 0, 0, 0, 69'h0, 32'h0BAD_F00D, 0, 0);
    foreach (tbl[i]) begin
      run_access(tbl[i], stallCyc, reqCyc, snap, moved);
      nVectors++;
      if (stallCyc != tbl[i].expStall) begin
        nMiscompares++;
        $display("[TB] FAIL %s stall cycles: got %0d expected %0d", tbl[i].name, stallCyc, tbl[i].expStall);
      end
      nVectors++;
      if (reqCyc != tbl[i].expReq) begin
        nMiscompares++;
        $display("[TB] FAIL %s req cycles: got %0d expected %0d", tbl[i].name, reqCyc, tbl[i].expReq);
      end
      exp = expQ.pop_front();
      nVectors++;
      if (wbActual !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL %s MEM/WB: got %h expected %h", tbl[i].name, wbActual, exp);
      end
    end
  endtask

  task automatic test_store_lanes();
    vec_t tbl[3];
    int stallCyc, reqCyc; logic [68:0] snap; logic moved; wb_t exp;
    tbl[0] = mk("sb", 1,1,0, SC_BYTE, LC_NONE, 32'h1003, 32'h0000_00AB, 32'h1003, 32'h00A0_0023, 4'd6,
                32'h0, 3, 0, 4, 3, {1'b1, 4'b1000, 32'h1000, 32'hABAB_ABAB}, 32'h1003, 0, 0);
    tbl[1] = mk("sh", 1,1,0, SC_HALF, LC_NONE, 32'h1002, 32'h1234_BEEF, 32'h1002, 32'h00B0_1023, 4'd7,
                32'h0, 2, 0, 3, 2, {1'b1, 4'b1100, 32'h1000, 32'hBEEF_BEEF}, 32'h1002, 0, 0);
    tbl[2] = mk("sw", 1,1,0, SC_WORD, LC_NONE, 32'h100C, 32'hDEAD_BEEF, 32'h100C, 32'h00C0_2023, 4'd8,
                32'h0, 1, 0, 2, 1, {1'b1, 4'b1111, 32'h100C, 32'hDEAD_BEEF}, 32'h100C, 0, 0);
    foreach (tbl[i]) begin
      run_access(tbl[i], stallCyc, reqCyc, snap, moved);
      nVectors++;
      if (stallCyc != tbl[i].expStall) begin
        nMiscompares++;
        $display("[TB] FAIL %s stall cycles: got %0d expected %0d", tbl[i].name, stallCyc, tbl[i].expStall);
      end
      nVectors++;
      if (reqCyc != tbl[i].expReq) begin
        nMiscompares++;
        $display("[TB] FAIL %s req cycles: got %0d expected %0d", tbl[i].name, reqCyc, tbl[i].expReq);
      end
      nVectors++;
      if (snap !== tbl[i].expBus) begin
        nMiscompares++;
        $display("[TB] FAIL %s bus {we,be,addr,wdata}: got %h expected %h", tbl[i].name, snap, tbl[i].expBus);
      end
      nVectors++;
      if (moved !== 1'b0) begin
        nMiscompares++;
        $display("[TB] FAIL %s bus stable while busy: got moved=%b expected 0", tbl[i].name, moved);
      end
      exp = expQ.pop_front();
      nVectors++;
      if (wbActual !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL %s MEM/WB: got %h expected %h", tbl[i].name, wbActual, exp);
      end
    end
  endtask

  task automatic test_loads();
    vec_t tbl[4];
    int stallCyc, reqCyc; logic [68:0] snap; logic moved; wb_t exp;
    tbl[0] = mk("lh", 1,0,1, SC_NONE, LC_LH, 32'h2002, 32'h0, 32'h2002, 32'h0020_1003, 4'd2,
                32'h8001_7FFF, 1, 0, 2, 1, {1'b0, 4'b1111, 32'h2000, 32'h0}, 32'hFFFF_8001, 0, 0);
    tbl[1] = mk("lbu", 1,0,1, SC_NONE, LC_LBU, 32'h2001, 32'h0, 32'h2001, 32'h0020_4003, 4'd2,
                32'h8001_7FFF, 2, 0, 3, 2, {1'b0, 4'b1111, 32'h2000, 32'h0}, 32'h0000_007F, 0, 0);
    tbl[2] = mk("lhu", 1,0,1, SC_NONE, LC_LHU, 32'h2000, 32'h0, 32'h2000, 32'h0020_5003, 4'd2,
                32'h8001_7FFF, 1, 0, 2, 1, {1'b0, 4'b1111, 32'h2000, 32'h0}, 32'h0000_7FFF, 0, 0);
    tbl[3] = mk("lw", 1,0,1, SC_NONE, LC_LW, 32'h2004, 32'h0, 32'h2004, 32'h0020_2003, 4'd2,
                32'hCAFE_BABE, 3, 0, 4, 3, {1'b0, 4'b1111, 32'h2004, 32'h0}, 32'hCAFE_BABE, 0, 0);
    foreach (tbl[i]) begin
      run_access(tbl[i], stallCyc, reqCyc, snap, moved);
      nVectors++;
      if (stallCyc != tbl[i].expStall) begin
        nMiscompares++;
        $display("[TB] FAIL %s stall cycles: got %0d expected %0d", tbl[i].name, stallCyc, tbl[i].expStall);
      end
      nVectors++;
      if (snap !== tbl[i].expBus) begin
        nMiscompares++;
        $display("[TB] FAIL %s bus {we,be,addr,wdata}: got %h expected %h", tbl[i].name, snap, tbl[i].expBus);
      end
      exp = expQ.pop_front();
      nVectors++;
      if (wbActual !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL %s MEM/WB: got %h expected %h", tbl[i].name, wbActual, exp);
      end
    end
  endtask

  task automatic test_misaligned();
    vec_t tbl[3];
    int stallCyc, reqCyc; logic [68:0] snap; logic moved; wb_t exp;
    tbl[0] = mk("lw_mis", 1,0,1, SC_NONE, LC_LW, 32'h2002, 32'h0, 32'h2002, 32'h0020_2083, 4'd2,
                32'h0, 0, 0, 0, 0, 69'h0, 32'h0, 1, 0);
    tbl[1] = mk("sh_mis", 1,1,0, SC_HALF, LC_NONE, 32'h1001, 32'h5555_5555, 32'h1001, 32'h00B0_10A3, 4'd7,
                32'h0, 0, 0, 0, 0, 69'h0, 32'h0, 1, 0);
    tbl[2] = mk("lhu_mis", 1,0,1, SC_NONE, LC_LHU, 32'h2003, 32'h0, 32'h2003, 32'h0020_5083, 4'd2,
                32'h0, 0, 0, 0, 0, 69'h0, 32'h0, 1, 0);
    foreach (tbl[i]) begin
      run_access(tbl[i], stallCyc, reqCyc, snap, moved);
      nVectors++;
      if (stallCyc != 0) begin
        nMiscompares++;
        $display("[TB] FAIL %s stall cycles: got %0d expected 0", tbl[i].name, stallCyc);
      end
      nVectors++;
      if (reqCyc != 0) begin
        nMiscompares++;
        $display("[TB] FAIL %s req cycles: got %0d expected 0", tbl[i].name, reqCyc);
      end
      exp = expQ.pop_front();
      nVectors++;
      if (wbActual !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL %s MEM/WB: got %h expected %h", tbl[i].name, wbActual, exp);
      end
    end
  endtask

  // The ack lands on the same edge as the timeout and again during RESP; both must lose
  task automatic test_timeout();
    vec_t v;
    int stallCyc, reqCyc; logic [68:0] snap; logic moved; wb_t exp;
    v = mk("timeout", 1,0,1, SC_NONE, LC_LW, 32'h3000, 32'h0, 32'h3000, 32'h0030_2003, 4'd2,
           32'h55AA_55AA, ACK_TIMEOUT, 1, ACK_TIMEOUT + 1, ACK_TIMEOUT,
           {1'b0, 4'b1111, 32'h3000, 32'h0}, 32'h0, 0, 1);
    run_access(v, stallCyc, reqCyc, snap, moved);
    nVectors++;
    if (reqCyc != v.expReq) begin
      nMiscompares++;
      $display("[TB] FAIL timeout req cycles: got %0d expected %0d", reqCyc, v.expReq);
    end
    nVectors++;
    if (stallCyc != v.expStall) begin
      nMiscompares++;
      $display("[TB] FAIL timeout stall cycles: got %0d expected %0d", stallCyc, v.expStall);
    end
    exp = expQ.pop_front();
    nVectors++;
    if (wbActual !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL timeout MEM/WB: got %h expected %h", wbActual, exp);
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    int stallCyc, reqCyc, startCyc; logic [68:0] snap; logic moved; wb_t exp;
    a = mk("b2b_lw", 1,0,1, SC_NONE, LC_LW, 32'h4000, 32'h0, 32'h4000, 32'h0040_2003, 4'd2,
           32'h1122_3344, 1, 0, 2, 1, {1'b0, 4'b1111, 32'h4000, 32'h0}, 32'h1122_3344, 0, 0);
    b = mk("b2b_lb", 1,0,1, SC_NONE, LC_LB, 32'h4003, 32'h0, 32'h4003, 32'h0040_3003, 4'd9,
           32'h8011_2233, 2, 0, 3, 2, {1'b0, 4'b1111, 32'h4000, 32'h0}, 32'hFFFF_FF80, 0, 0);
    startCyc = cycleCnt;
    run_access(a, stallCyc, reqCyc, snap, moved);
    exp = expQ.pop_front();
    nVectors++;
    if (wbActual !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL b2b_lw MEM/WB: got %h expected %h", wbActual, exp);
    end
    run_access(b, stallCyc, reqCyc, snap, moved);
    nVectors++;
    if (stallCyc != b.expStall) begin
      nMiscompares++;
      $display("[TB] FAIL b2b_lb stall cycles: got %0d expected %0d", stallCyc, b.expStall);
    end
    exp = expQ.pop_front();
    nVectors++;
    if (wbActual !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL b2b_lb MEM/WB: got %h expected %h", wbActual, exp);
    end
    nVectors++;
    if ((cycleCnt - startCyc) != 7) begin
      nMiscompares++;
      $display("[TB] FAIL b2b occupancy: got %0d cycles expected 7", cycleCnt - startCyc);
    end
  endtask

  task automatic test_reset_in_busy();
    wb_t exp;
    cs = 1; dmR = 1; lc = LC_LW; sc = SC_NONE; dmemAddr = 32'h3000; dataIn = 0;
    aluo = 32'h3000; instr = 32'h0030_2003; doingOp = 4'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nVectors++;
    if (bus.mem_req !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL rst_busy req before reset: got %b expected 1", bus.mem_req);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cs = 0; dmR = 0; lc = LC_NONE; aluo = 0; instr = 0; doingOp = 0;
    expQ.push_back('0);
    @(negedge clk);
    nVectors++;
    if ({bus.mem_req, oStall} !== 2'b00) begin
      nMiscompares++;
      $display("[TB] FAIL rst_busy req/stall after reset: got %b%b expected 00", bus.mem_req, oStall);
    end
    exp = expQ.pop_front();
    nVectors++;
    if (wbActual !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL rst_busy MEM/WB after reset: got %h expected %h", wbActual, exp);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    expQ.push_back('0);
    repeat (2) @(negedge clk);
    nVectors++;
    if ({bus.mem_req, oStall} !== 2'b00) begin
      nMiscompares++;
      $display("[TB] FAIL rst_busy late ack req/stall: got %b%b expected 00", bus.mem_req, oStall);
    end
    exp = expQ.pop_front();
    nVectors++;
    if (wbActual !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL rst_busy late ack MEM/WB: got %h expected %h", wbActual, exp);
    end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_store_lanes();
    test_loads();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_in_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
